rcb_frl_tap_calib_ctrl: RTL and testbench
=========================================

# rcb_frl_tap_calib_ctrl

Calibration sequencer for the Fast Radio Link receive-side 7-bit up/down tap counter. It owns the counter's `count`/`ud` command pair. On request it clears the counter and sweeps taps 0..127, scoring each tap against a per-cycle training-pattern match flag. It then finds the widest passing window and steps the counter back to the window centre. It sits between the FRL link-training logic (start/status) and the tap counter feeding the receive delay line.

## Interface
- `SETTLE_CYCLES`, default 8: hold cycles after every tap change before sampling; minimum 1.
- `SAMPLE_CYCLES`, default 16: cycles `pattern_ok` is scored per tap; minimum 1.
- `RETRY_MAX`, default 3: extra sweeps after a failed sweep. Used only with `RCB_FRL_CALIB_RETRY_EN`.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to calibrate. Ignored while `busy`.
- `pattern_ok` in 1: per-cycle training-word match from the deserializer compare.
- `tap_value` in 7: tap counter's current value.
- `count` out 1: counter command bit. Reset 0.
- `ud` out 1: counter command bit. Reset 1.
- `busy` out 1: calibration in progress. Reset 0.
- `done` out 1: success, held until the next accepted `start`. Reset 0.
- `fail` out 1: no passing tap found, held until the next accepted `start`. Reset 0.
- `center_tap` out 7: chosen tap. Reset 0.
- `window_width` out 8: widest window width, range 0..128. Reset 0.

## Operation
- Counter commands on {count,ud}:
  - 00: clear the counter to 0.
  - 01: hold.
  - 10: decrement.
  - 11: increment.
- Outside CLEAR/STEP/SEEK pulses the block drives hold (01).
- States: IDLE, CLEAR, SETTLE, SAMPLE, STEP, EVAL, SEEK, DONE, FAIL.
- IDLE → CLEAR on `start`. CLEAR drives 00 for 1 cycle, clears `done`/`fail`/run trackers and sets `busy`.
- CLEAR → SETTLE. SETTLE holds for SETTLE_CYCLES and ignores `pattern_ok`.
- SETTLE → SAMPLE. SAMPLE runs SAMPLE_CYCLES; the tap passes only if `pattern_ok` = 1 on every sampled cycle.
- After the last sample cycle, the run tracker updates:
  - On pass: if run_len = 0 then run_start = tap; run_len++; if run_len > best_len then best = run.
  - On fail: run_len = 0.
  - Strictly-greater replace, so the earliest of equal-width windows wins.
- SAMPLE → STEP if `tap_value` < 127. STEP drives 11 for exactly 1 cycle, then returns to SETTLE.
- SAMPLE → EVAL at tap 127. Never increment past 127; the counter wraps and must not be commanded to.
- EVAL, best_len = 0: go to FAIL.
- EVAL, best_len > 0:
  - target = best_start + ((best_len − 1) >> 1), computed at 8 bits and truncated to 7.
  - `window_width` = best_len.
  - Go to SEEK.
- SEEK while `tap_value` > target: drive 10 for 1 cycle, then hold 1 cycle before re-comparing. This absorbs the counter's one-cycle update.
- SEEK → DONE when `tap_value` = target. Never decrement at tap 0.
- DONE: `center_tap` = target, `done` = 1, `busy` = 0, then IDLE.
- FAIL: drive 00 for 1 cycle (tap returns to 0), `fail` = 1, `busy` = 0, `center_tap` = 0, then IDLE.
- `rst` at any time: immediate return to IDLE with all reset values. The sweep is abandoned with no partial results.

## Timing
- Cycles per tap = SETTLE_CYCLES + SAMPLE_CYCLES, plus 1 STEP cycle.
- Defaults: `start` to EVAL = 1 + 128·24 + 127 = 3200 cycles.
- EVAL takes 1 cycle. SEEK takes 2·(127 − target) cycles.
- `busy` rises the cycle after accepted `start` and falls with `done`/`fail`.
- `done`/`fail`/`center_tap`/`window_width` update in the same cycle.
- `start` coincident with DONE/FAIL is ignored (`busy` is still 1).

## Configuration
- Macro `RCB_FRL_CALIB_RETRY_EN`.
- Defined:
  - EVAL with best_len = 0 re-enters CLEAR while retries_used < RETRY_MAX, incrementing retries_used. `busy` stays high and `fail` stays low.
  - `fail` asserts only after RETRY_MAX+1 failed sweeps. retries_used clears on accepted `start`.
- Undefined: the first failed sweep goes straight to FAIL; the retry counter and `RETRY_MAX` are absent.

## Structure
- Package `rcb_frl_calib_pkg` holds:
  - the state enum;
  - the counter command constants CMD_CLEAR = 2'b00, CMD_HOLD = 2'b01, CMD_DEC = 2'b10, CMD_INC = 2'b11;
  - TAP_MAX = 7'd127.
- Sub-module `rcb_frl_tap_window_tracker`:
  - holds run_start, run_len, best_start and best_len;
  - inputs: clear, tap_valid, tap_pass, tap.
- The top module holds the FSM, the settle/sample counters and SEEK.

## Test plan
- Bench contains a behavioural tap counter; `pattern_ok` = 1 for taps 40..59 only → width 20, center 49, final `tap_value` 49, `done` = 1 at cycle 3200 + 1 + 156.
- `pattern_ok` = 0 everywhere, macro undefined → `fail` = 1, `tap_value` 0, `center_tap` 0. Macro defined → `fail` only after 4 sweeps.
- Windows 10..14 and 100..104 → earlier wins: width 5, center 12. All taps pass → width 128, center 63.
- Window 120..127 (touches the sweep end) → width 8, center 123. No `ud` increment is ever issued at tap 127.
- A single `pattern_ok` = 0 glitch in the SAMPLE of tap 50 within window 40..59 → best window 40..49, center 44. The same glitch in SETTLE → no effect, center 49.
- `rst` pulse mid-sweep at tap 70 → all outputs at reset values immediately. `start` during `busy` is ignored. A new `start` yields the correct result.

Source files
------------

// File: rtl/rcb_frl_tap_calib_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rcb_frl_calib_pkg
// Shared definitions for the FRL receive tap calibration sequencer:
//   - calib_state_e : sequencer state encoding
//   - CMD_*         : {count,ud} command codes for the 7-bit up/down tap counter
//   - TAP_MAX       : last tap of the sweep
//   - window_center : centre tap of a passing window
// ----------------------------------------------------------------------------
package rcb_frl_calib_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CLEAR  = 4'd1,
      ST_SETTLE = 4'd2,
      ST_SAMPLE = 4'd3,
      ST_STEP   = 4'd4,
      ST_EVAL   = 4'd5,
      ST_SEEK   = 4'd6,
      ST_DONE   = 4'd7,
      ST_FAIL   = 4'd8
   } calib_state_e;

   localparam logic [1:0] CMD_CLEAR = 2'b00;
   localparam logic [1:0] CMD_HOLD  = 2'b01;
   localparam logic [1:0] CMD_DEC   = 2'b10;
   localparam logic [1:0] CMD_INC   = 2'b11;

   localparam logic [6:0] TAP_MAX = 7'd127;

   // Lower-middle tap of a window; summed at 8 bits, then truncated to 7.
   function automatic logic [6:0] window_center(input logic [6:0] start,
                                                input logic [7:0] len);
      logic [7:0] sum;
      sum = {1'b0, start} + ((len - 8'd1) >> 1);
      return sum[6:0];
   endfunction

endpackage

// File: rtl/rcb_frl_tap_calib_ctrl_if.sv
// ----------------------------------------------------------------------------
// rcb_frl_tap_calib_ctrl_if
// Bundle between the calibration sequencer (slave side) and its environment
// (link-training logic + tap counter, master side).
//   start        : one-cycle calibration request
//   pattern_ok   : per-cycle training-word match
//   tap_value    : tap counter current value
//   count, ud    : tap counter command pair
//   busy/done/fail, center_tap, window_width : status and results
// ----------------------------------------------------------------------------
interface rcb_frl_tap_calib_ctrl_if;
   logic       start;
   logic       pattern_ok;
   logic [6:0] tap_value;
   logic       count;
   logic       ud;
   logic       busy;
   logic       done;
   logic       fail;
   logic [6:0] center_tap;
   logic [7:0] window_width;

   modport master (
      output start, pattern_ok, tap_value,
      input  count, ud, busy, done, fail, center_tap, window_width
   );

   modport slave (
      input  start, pattern_ok, tap_value,
      output count, ud, busy, done, fail, center_tap, window_width
   );
endinterface

// File: rtl/rcb_frl_tap_calib_ctrl_window_tracker.sv
// ----------------------------------------------------------------------------
// rcb_frl_tap_window_tracker
// Tracks the current run of consecutive passing taps and the widest run seen.
//   clk, rst       : clock, asynchronous active-high reset
//   clear_i        : drop all run/best state (start of a sweep)
//   tap_valid_i    : a tap verdict is presented this cycle
//   tap_pass_i     : verdict (1 = tap passed)
//   tap_i          : tap the verdict belongs to
//   best_start_o   : first tap of the widest run
//   best_len_o     : width of the widest run (0..128)
// Only a strictly longer run replaces the best, so ties keep the earliest.
// ----------------------------------------------------------------------------
module rcb_frl_tap_window_tracker (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       tap_valid_i,
   input  logic       tap_pass_i,
   input  logic [6:0] tap_i,
   output logic [6:0] best_start_o,
   output logic [7:0] best_len_o
);

   logic [6:0] run_start_q, run_start_d;
   logic [7:0] run_len_q,   run_len_d;
   logic [6:0] best_start_q, best_start_d;
   logic [7:0] best_len_q,   best_len_d;

   always_comb begin
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      if (clear_i) begin
         run_start_d  = 7'd0;
         run_len_d    = 8'd0;
         best_start_d = 7'd0;
         best_len_d   = 8'd0;
      end else if (tap_valid_i) begin
         if (tap_pass_i) begin
            if (run_len_q == 8'd0) begin
               run_start_d = tap_i;
            end
            run_len_d = run_len_q + 8'd1;
            if (run_len_d > best_len_q) begin
               best_start_d = run_start_d;
               best_len_d   = run_len_d;
            end
         end else begin
            run_len_d = 8'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_start_q  <= 7'd0;
         run_len_q    <= 8'd0;
         best_start_q <= 7'd0;
         best_len_q   <= 8'd0;
      end else begin
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   assign best_start_o = best_start_q;
   assign best_len_o   = best_len_q;

endmodule

// File: rtl/rcb_frl_tap_calib_ctrl.sv
// ----------------------------------------------------------------------------
// rcb_frl_tap_calib_ctrl
// FRL receive tap calibration sequencer: clears the tap counter, sweeps taps
// 0..127 scoring each against pattern_ok, picks the widest passing window and
// steps the counter back down to its centre.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rcb_frl_tap_calib_ctrl_if.slave (start, pattern_ok, tap_value in;
//              count, ud, busy, done, fail, center_tap, window_width out)
// Optional feature macro: RCB_FRL_CALIB_RETRY_EN -- a failed sweep is retried
// up to RETRY_MAX times before fail is raised.
// ----------------------------------------------------------------------------
module rcb_frl_tap_calib_ctrl
   import rcb_frl_calib_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16
`ifdef RCB_FRL_CALIB_RETRY_EN
   ,
   parameter int RETRY_MAX = 3
`endif
) (
   input logic                     clk,
   input logic                     rst,
   rcb_frl_tap_calib_ctrl_if.slave bus
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);

   calib_state_e state_q, state_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         pass_q, pass_d;
   logic         seek_wait_q, seek_wait_d;
   logic [6:0]   target_q, target_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         fail_q, fail_d;
   logic [6:0]   center_q, center_d;
   logic [7:0]   width_q, width_d;
`ifdef RCB_FRL_CALIB_RETRY_EN
   logic [7:0]   retries_q, retries_d;
`endif

   logic [1:0]   cmd;
   logic         trk_clear;
   logic         trk_valid;
   logic         tap_pass;
   logic [6:0]   best_start;
   logic [7:0]   best_len;
   logic [6:0]   eval_target;

   // The current cycle's pattern_ok is folded in so the last sample counts.
   assign tap_pass    = pass_q & bus.pattern_ok;
   assign eval_target = window_center(best_start, best_len);

   rcb_frl_tap_window_tracker u_tracker (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (trk_clear),
      .tap_valid_i  (trk_valid),
      .tap_pass_i   (tap_pass),
      .tap_i        (bus.tap_value),
      .best_start_o (best_start),
      .best_len_o   (best_len)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      seek_wait_d = seek_wait_q;
      target_d    = target_q;
      busy_d      = busy_q;
      done_d      = done_q;
      fail_d      = fail_q;
      center_d    = center_q;
      width_d     = width_q;
`ifdef RCB_FRL_CALIB_RETRY_EN
      retries_d   = retries_q;
`endif
      cmd         = CMD_HOLD;
      trk_clear   = 1'b0;
      trk_valid   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_CLEAR;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               fail_d  = 1'b0;
`ifdef RCB_FRL_CALIB_RETRY_EN
               retries_d = 8'd0;
`endif
            end
         end
         ST_CLEAR: begin
            cmd       = CMD_CLEAR;
            trk_clear = 1'b1;
            cnt_d     = 16'd0;
            state_d   = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 16'd0;
               pass_d  = 1'b1;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SAMPLE: begin
            pass_d = tap_pass;
            if (cnt_q == SAMPLE_LAST) begin
               trk_valid = 1'b1;
               cnt_d     = 16'd0;
               // Stop at the top tap: the counter would wrap on another INC.
               state_d   = (bus.tap_value < TAP_MAX) ? ST_STEP : ST_EVAL;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_STEP: begin
            cmd     = CMD_INC;
            state_d = ST_SETTLE;
         end
         ST_EVAL: begin
            if (best_len == 8'd0) begin
`ifdef RCB_FRL_CALIB_RETRY_EN
               if (retries_q < 8'(RETRY_MAX)) begin
                  retries_d = retries_q + 8'd1;
                  state_d   = ST_CLEAR;
               end else begin
                  state_d  = ST_FAIL;
                  fail_d   = 1'b1;
                  busy_d   = 1'b0;
                  center_d = 7'd0;
                  width_d  = 8'd0;
               end
`else
               state_d  = ST_FAIL;
               fail_d   = 1'b1;
               busy_d   = 1'b0;
               center_d = 7'd0;
               width_d  = 8'd0;
`endif
            end else if (eval_target == bus.tap_value) begin
               // Already sitting on the centre (window is tap 127 alone).
               state_d  = ST_DONE;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               center_d = eval_target;
               width_d  = best_len;
            end else begin
               target_d    = eval_target;
               seek_wait_d = 1'b0;
               state_d     = ST_SEEK;
            end
         end
         ST_SEEK: begin
            // Alternate DEC and a hold cycle; the compare in the hold cycle
            // sees the counter value after its one-cycle update.
            if (!seek_wait_q) begin
               if (bus.tap_value > target_q) begin
                  cmd         = CMD_DEC;
                  seek_wait_d = 1'b1;
               end else begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  center_d = target_q;
                  width_d  = best_len;
               end
            end else begin
               seek_wait_d = 1'b0;
               if (bus.tap_value == target_q) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  center_d = target_q;
                  width_d  = best_len;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            cmd     = CMD_CLEAR;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'd0;
         pass_q      <= 1'b0;
         seek_wait_q <= 1'b0;
         target_q    <= 7'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         center_q    <= 7'd0;
         width_q     <= 8'd0;
`ifdef RCB_FRL_CALIB_RETRY_EN
         retries_q   <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pass_q      <= pass_d;
         seek_wait_q <= seek_wait_d;
         target_q    <= target_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         center_q    <= center_d;
         width_q     <= width_d;
`ifdef RCB_FRL_CALIB_RETRY_EN
         retries_q   <= retries_d;
`endif
      end
   end

   assign bus.count        = cmd[1];
   assign bus.ud           = cmd[0];
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.fail         = fail_q;
   assign bus.center_tap   = center_q;
   assign bus.window_width = width_q;

endmodule

// File: tb/tb_rcb_frl_tap_calib_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rcb_frl_tap_calib_ctrl
// Drives the sequencer with a behavioural 7-bit up/down tap counter and a
// per-tap pass mask, and compares results against a window-search model.
// ----------------------------------------------------------------------------
module tb_rcb_frl_tap_calib_ctrl;

   localparam int SETTLE = 8;
   localparam int SAMPLE = 16;
`ifdef RCB_FRL_CALIB_RETRY_EN
   localparam int SWEEPS = 4;
`else
   localparam int SWEEPS = 1;
`endif
   localparam int SWEEP_LEN = 1 + 128 * (SETTLE + SAMPLE) + 127 + 1;   // CLEAR..EVAL

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rcb_frl_tap_calib_ctrl_if bus_if ();

   rcb_frl_tap_calib_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .SAMPLE_CYCLES (SAMPLE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural tap counter (not reset by rst, starts at an arbitrary value)
   logic [6:0]   tap_m = 7'd93;
   logic [6:0]   tap_next;
   int           dwell = 0;
   int           ill_inc = 0;
   int           ill_dec = 0;
   logic [127:0] mask_r = '0;
   logic         g_en = 1'b0;
   logic [6:0]   g_tap = 7'd0;
   int           g_dwell = 0;

   always_comb begin
      tap_next = tap_m;
      case ({bus_if.count, bus_if.ud})
         2'b00: tap_next = 7'd0;
         2'b10: tap_next = tap_m - 7'd1;
         2'b11: tap_next = tap_m + 7'd1;
         default: tap_next = tap_m;
      endcase
   end

   always @(posedge clk) begin
      tap_m <= tap_next;
      dwell <= (tap_next != tap_m) ? 0 : dwell + 1;
      if (bus_if.count && bus_if.ud && tap_m == 7'd127) ill_inc <= ill_inc + 1;
      if (bus_if.count && !bus_if.ud && tap_m == 7'd0) ill_dec <= ill_dec + 1;
   end

   assign bus_if.tap_value  = tap_m;
   assign bus_if.pattern_ok = mask_r[tap_m] && !(g_en && tap_m == g_tap && dwell == g_dwell);

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] win(input int lo, input int hi);
      logic [127:0] m;
      m = '0;
      for (int t = lo; t <= hi && t < 128; t++) m[t] = 1'b1;
      return m;
   endfunction

   // Reference: widest run of passing taps, earliest on ties.
   function automatic void model(input logic [127:0] eff, output int w, output int c);
      int run, rs, bs;
      run = 0; rs = 0; bs = 0; w = 0;
      for (int t = 0; t < 128; t++) begin
         if (eff[t]) begin
            if (run == 0) rs = t;
            run++;
            if (run > w) begin w = run; bs = rs; end
         end else begin
            run = 0;
         end
      end
      c = (w > 0) ? (bs + (w - 1) / 2) % 128 : 0;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".count"},  int'(bus_if.count), 0);
      chk({tag, ".ud"},     int'(bus_if.ud), 1);
      chk({tag, ".busy"},   int'(bus_if.busy), 0);
      chk({tag, ".done"},   int'(bus_if.done), 0);
      chk({tag, ".fail"},   int'(bus_if.fail), 0);
      chk({tag, ".center"}, int'(bus_if.center_tap), 0);
      chk({tag, ".width"},  int'(bus_if.window_width), 0);
   endtask

   // One full calibration; optional glitch (tap, dwell) and a stray start at k=100.
   task automatic run_case(input string tag, input logic [127:0] mask,
                           input int gtap, input int gdw, input bit stray_start);
      logic [127:0] eff;
      int w, c, k, lat, inc0, dec0;
      mask_r  = mask;
      g_en    = (gtap >= 0);
      g_tap   = 7'(gtap);
      g_dwell = gdw;
      eff = mask;
      if (gtap >= 0 && gdw >= SETTLE && gdw < SETTLE + SAMPLE) eff[gtap] = 1'b0;
      model(eff, w, c);
      lat = (w > 0) ? SWEEP_LEN + 2 * (127 - c) : SWEEP_LEN * SWEEPS;
      inc0 = ill_inc; dec0 = ill_dec;
      @(negedge clk) bus_if.start = 1'b1;
      @(negedge clk) bus_if.start = 1'b0;
      chk({tag, ".busy_rise"}, int'(bus_if.busy), 1);
      k = 0;
      while (!(bus_if.done || bus_if.fail) && k < 20000) begin
         @(negedge clk);
         k++;
         bus_if.start = (stray_start && k == 100);
      end
      bus_if.start = 1'b0;
      chk({tag, ".latency"}, k, lat);
      chk({tag, ".done"},    int'(bus_if.done), (w > 0) ? 1 : 0);
      chk({tag, ".fail"},    int'(bus_if.fail), (w > 0) ? 0 : 1);
      chk({tag, ".busy"},    int'(bus_if.busy), 0);
      chk({tag, ".width"},   int'(bus_if.window_width), w);
      chk({tag, ".center"},  int'(bus_if.center_tap), c);
      @(negedge clk);
      @(negedge clk);
      chk({tag, ".tap"},     int'(tap_m), c);
      chk({tag, ".no_inc_at_127"}, ill_inc - inc0, 0);
      chk({tag, ".no_dec_at_0"},   ill_dec - dec0, 0);
      $display("txn %s: width=%0d center=%0d done=%0d fail=%0d latency=%0d tap=%0d",
               tag, bus_if.window_width, bus_if.center_tap, bus_if.done, bus_if.fail, k, tap_m);
      g_en = 1'b0;
   endtask

   initial begin
      int k;
      logic [127:0] m;
      bus_if.start = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("in_reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("after_reset");

      run_case("win40_59",      win(40, 59), -1, 0, 1'b0);
      chk("win40_59.center_const", int'(bus_if.center_tap), 49);
      run_case("all_zero",      '0, -1, 0, 1'b0);
      run_case("two_windows",   win(10, 14) | win(100, 104), -1, 0, 1'b0);
      chk("two_windows.center_const", int'(bus_if.center_tap), 12);
      run_case("all_pass",      ~128'd0, -1, 0, 1'b0);
      run_case("win120_127",    win(120, 127), -1, 0, 1'b0);
      run_case("glitch_sample", win(40, 59), 50, SETTLE + 4, 1'b0);
      chk("glitch_sample.center_const", int'(bus_if.center_tap), 44);
      run_case("glitch_settle", win(40, 59), 50, 3, 1'b0);

      // Reset mid-sweep at tap 70
      mask_r = win(40, 59);
      @(negedge clk) bus_if.start = 1'b1;
      @(negedge clk) bus_if.start = 1'b0;
      k = 0;
      while (tap_m != 7'd70 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("mid_rst.reached_tap70", int'(tap_m), 70);
      rst = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      $display("txn mid_rst: reset applied at tap=%0d busy=%0d", tap_m, bus_if.busy);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("mid_rst.idle_busy", int'(bus_if.busy), 0);

      run_case("restart_stray_start", win(40, 59), -1, 0, 1'b1);

      for (int r = 0; r < 2; r++) begin
         m = '0;
         for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
            int s;
            s = int'($urandom_range(0, 127));
            m = m | win(s, s + int'($urandom_range(1, 30)) - 1);
         end
         run_case($sformatf("random%0d", r), m, -1, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
